// File: rtl/fp_sqrt_seq.sv
// Multi-cycle IEEE-754 single-precision square root: restoring digit-by-digit
// root extraction (one root bit per cycle) followed by round-to-nearest-even.
module fp_sqrt_seq #(
    parameter bit FTZ   = 1'b1,
    parameter bit ROUND = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        Exception,
    output logic        Underflow,
    output logic        Overflow
);

    typedef enum logic [1:0] {IDLE, CALC, RND, DONE} state_t;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    state_t             state_q, state_d;
    logic        [4:0]  cnt_q, cnt_d;
    logic        [49:0] rad_q, rad_d;
    logic        [27:0] rem_q, rem_d;
    logic        [24:0] root_q, root_d;
    logic        [7:0]  exp_q, exp_d;
    logic        [31:0] result_q, result_d;
    logic               exc_q, exc_d;
    logic               unf_q, unf_d;
    logic               ovf_q, ovf_d;
    logic signed [29:0] trial;
    logic               keep;

    // Guard is root[0]; a carry out of the 24-bit mantissa only happens when
    // every retained root bit is 1, in which case the fraction wraps to zero.
    function automatic logic [31:0] round_pack(input logic [24:0] root,
                                               input logic        sticky,
                                               input logic [7:0]  exp_in);
        logic       inc;
        logic [22:0] frac;
        logic [7:0]  exp_out;
        inc     = ROUND & root[0] & (sticky | root[1]);
        frac    = root[23:1] + {22'd0, inc};
        exp_out = exp_in + {7'd0, inc & (&root[24:1])};
        return {1'b0, exp_out, frac};
    endfunction

    assign trial = $signed({rem_q, rad_q[49:48]}) - $signed({3'b000, root_q, 2'b01});
    assign keep  = (trial[29:28] == 2'b00);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rad_d    = rad_q;
        rem_d    = rem_q;
        root_d   = root_q;
        exp_d    = exp_q;
        result_d = result_q;
        exc_d    = exc_q;
        unf_d    = unf_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = DONE;
                    if (a[30:23] == 8'hFF && a[22:0] != 23'd0) begin
                        result_d = QNAN;
                        exc_d    = 1'b1;
                    end else if (a == 32'h8000_0000) begin
                        result_d = 32'h8000_0000;
                    end else if (a == 32'h0000_0000) begin
                        result_d = 32'h0000_0000;
                    end else if (a[31]) begin
                        result_d = QNAN;
                        exc_d    = 1'b1;
                    end else if (a[30:23] == 8'hFF) begin
                        result_d = POS_INF;
                        ovf_d    = 1'b1;
                    end else if (a[30:23] == 8'h00) begin
                        result_d = 32'h0000_0000;
                        unf_d    = FTZ;
                    end else begin
                        // Odd biased exponent means an even unbiased one: shift by 25, else 26.
                        state_d = CALC;
                        cnt_d   = 5'd24;
                        rem_d   = '0;
                        root_d  = '0;
                        rad_d   = a[23] ? {2'b01, a[22:0], 25'd0} : {1'b1, a[22:0], 26'd0};
                        exp_d   = {1'b0, a[30:24]} + (a[23] ? 8'd64 : 8'd63);
                    end
                end
            end
            CALC: begin
                rad_d  = {rad_q[47:0], 2'b00};
                root_d = {root_q[23:0], keep};
                rem_d  = keep ? trial[27:0] : {rem_q[25:0], rad_q[49:48]};
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = RND;
            end
            RND: begin
                result_d = round_pack(root_q, |rem_q, exp_q);
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    exc_d   = 1'b0;
                    unf_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        cnt_q  <= cnt_d;
        rad_q  <= rad_d;
        rem_q  <= rem_d;
        root_q <= root_d;
        exp_q  <= exp_d;
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            exc_q    <= 1'b0;
            unf_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            unf_q    <= unf_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign Exception = exc_q;
    assign Underflow = unf_q;
    assign Overflow  = ovf_q;

endmodule

// File: tb/tb_fp_sqrt_seq.sv
// Directed bench for fp_sqrt_seq: normal roots, specials, latency,
// backpressure, mid-operation reset and back-to-back traffic.
module tb_fp_sqrt_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        Exception;
    logic        Underflow;
    logic        Overflow;

    int n_cmp = 0;
    int n_err = 0;

    fp_sqrt_seq #(.FTZ(1'b1), .ROUND(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .Exception(Exception),
        .Underflow(Underflow),
        .Overflow (Overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want)
        else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    // flags are {Exception, Underflow, Overflow}; hold = cycles of out_ready=0 after out_valid
    task automatic run_op(input string tag, input logic [31:0] val, input logic [31:0] want,
                          input logic [2:0] want_flags, input int want_lat, input int hold);
        int lat;
        int w;
        logic [31:0] held;
        out_ready = (hold == 0);
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk({tag, "/ready_before"}, 32'(in_ready), 32'd1);
        a        = val;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(want_lat));
        chk({tag, "/result"}, result, want);
        chk({tag, "/flags"}, {29'd0, Exception, Underflow, Overflow}, {29'd0, want_flags});
        held = result;
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            a        = 32'h4110_0000;
            @(posedge clk); #1;
            chk({tag, "/bp_result"}, result, held);
            chk({tag, "/bp_vld_rdy"}, {30'd0, out_valid, in_ready}, 32'd2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "/after_take"}, {30'd0, out_valid, in_ready}, 32'd1);
        chk({tag, "/flags_clr"}, {29'd0, Exception, Underflow, Overflow}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset/vld_rdy", {30'd0, out_valid, in_ready}, 32'd1);
        chk("reset/result", result, 32'd0);
        chk("reset/flags", {29'd0, Exception, Underflow, Overflow}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("sqrt4",    32'h4080_0000, 32'h4000_0000, 3'b000, 27, 0);
        run_op("sqrt2",    32'h4000_0000, 32'h3FB5_04F3, 3'b000, 27, 0);
        run_op("sqrt9",    32'h4110_0000, 32'h4040_0000, 3'b000, 27, 0);
        run_op("sqrt1",    32'h3F80_0000, 32'h3F80_0000, 3'b000, 27, 0);
        run_op("sqrt5_rne", 32'h40A0_0000, 32'h400F_1BBD, 3'b000, 27, 0);
        run_op("sqrt_qtr", 32'h3E80_0000, 32'h3F00_0000, 3'b000, 27, 0);
        run_op("sqrt_max", 32'h7F7F_FFFF, 32'h5F7F_FFFF, 3'b000, 27, 0);
        run_op("sqrt_minn", 32'h0080_0000, 32'h2000_0000, 3'b000, 27, 0);

        run_op("neg4",     32'hC080_0000, 32'h7FC0_0000, 3'b100, 1, 0);
        run_op("negzero",  32'h8000_0000, 32'h8000_0000, 3'b000, 1, 0);
        run_op("poszero",  32'h0000_0000, 32'h0000_0000, 3'b000, 1, 0);
        run_op("posinf",   32'h7F80_0000, 32'h7F80_0000, 3'b001, 1, 0);
        run_op("posdenorm", 32'h0000_0001, 32'h0000_0000, 3'b010, 1, 0);
        run_op("nan",      32'h7F80_0001, 32'h7FC0_0000, 3'b100, 1, 0);
        run_op("neginf",   32'hFF80_0000, 32'h7FC0_0000, 3'b100, 1, 0);
        run_op("negdenorm", 32'h8000_0001, 32'h7FC0_0000, 3'b100, 1, 0);

        run_op("bp_sqrt4", 32'h4080_0000, 32'h4000_0000, 3'b000, 27, 10);
        repeat (2) @(posedge clk);
        #1;
        chk("bp/no_phantom", {30'd0, out_valid, in_ready}, 32'd1);

        // Abort on the 10th CALC cycle, then a clean operation must still work.
        a        = 32'h4080_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("midrst/busy", {30'd0, out_valid, in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst/vld_rdy", {30'd0, out_valid, in_ready}, 32'd1);
        chk("midrst/result", result, 32'd0);
        run_op("midrst_sqrt9", 32'h4110_0000, 32'h4040_0000, 3'b000, 27, 0);

        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0)
                run_op("b2b_sqrt4", 32'h4080_0000, 32'h4000_0000, 3'b000, 27, 0);
            else
                run_op("b2b_sqrt2", 32'h4000_0000, 32'h3FB5_04F3, 3'b000, 27, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
